// File: rtl/mem_stage_pkg.sv
// Shared types and opcodes for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 8;

  localparam logic [OP_W-1:0] OPC_ADD  = 8'h01;
  localparam logic [OP_W-1:0] OPC_XOR  = 8'h02;
  localparam logic [OP_W-1:0] OPC_LD   = 8'h20;
  localparam logic [OP_W-1:0] OPC_ST   = 8'h21;
  localparam logic [OP_W-1:0] OPC_PUSH = 8'h22;
  localparam logic [OP_W-1:0] OPC_POP  = 8'h23;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUS  = 1'b1
  } ms_state_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ST) || (opc == OPC_PUSH) || (opc == OPC_POP);
  endfunction

  function automatic logic is_write_op(input logic [OP_W-1:0] opc);
    return (opc == OPC_ST) || (opc == OPC_PUSH);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// req/ack data bus between the memory stage (master) and memory (slave).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs LD/ST/PUSH/POP on the req/ack bus, passes other ops through,
// and presents writeback and SP-update results one pulse per operation.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [OP_W-1:0]   alu_control_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              alu_write_i,
  input  logic [DATA_W-1:0] sp_in_i,
  output logic              stall_o,
  mem_stage_if.master       mem,
  output logic              wb_valid_o,
  output logic              wb_write_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              sp_write_o,
  output logic [DATA_W-1:0] sp_data_o,
  output logic              align_err_o,
  output logic              bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  ms_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   opc_q, opc_d;
  logic [DATA_W-1:0] sp_in_q, sp_in_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              req_q, req_d;
  logic              stall_q, stall_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_write_q, wb_write_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              sp_write_q, sp_write_d;
  logic [DATA_W-1:0] sp_data_q, sp_data_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MS_IDLE;
      cnt_q       <= '0;
      opc_q       <= '0;
      sp_in_q     <= '0;
      cmd_q       <= '0;
      req_q       <= 1'b0;
      stall_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_write_q  <= 1'b0;
      wb_data_q   <= '0;
      sp_write_q  <= 1'b0;
      sp_data_q   <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opc_q       <= opc_d;
      sp_in_q     <= sp_in_d;
      cmd_q       <= cmd_d;
      req_q       <= req_d;
      stall_q     <= stall_d;
      wb_valid_q  <= wb_valid_d;
      wb_write_q  <= wb_write_d;
      wb_data_q   <= wb_data_d;
      sp_write_q  <= sp_write_d;
      sp_data_q   <= sp_data_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state and output logic; result pulses default low every cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opc_d       = opc_q;
    sp_in_d     = sp_in_q;
    cmd_d       = cmd_q;
    req_d       = req_q;
    wb_valid_d  = 1'b0;
    wb_write_d  = 1'b0;
    wb_data_d   = wb_data_q;
    sp_write_d  = 1'b0;
    sp_data_d   = sp_data_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      MS_IDLE: begin
        if (en_i) begin
          opc_d   = alu_control_i;
          sp_in_d = sp_in_i;
          cnt_d   = '0;
          if (!is_mem_op(alu_control_i)) begin
            wb_valid_d = 1'b1;
            wb_write_d = alu_write_i;
            wb_data_d  = alu_out_i;
          end else if (alu_out_i[0]) begin
            wb_valid_d  = 1'b1;
            align_err_d = 1'b1;
          end else begin
            state_d     = MS_BUS;
            req_d       = 1'b1;
            cmd_d.we    = is_write_op(alu_control_i);
            cmd_d.addr  = alu_out_i;
            cmd_d.wdata = store_data_i;
          end
        end
      end
      MS_BUS: begin
        // ack takes priority over a timeout falling on the same edge
        if (mem.ack) begin
          state_d    = MS_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          unique case (opc_q)
            OPC_LD: begin
              wb_write_d = 1'b1;
              wb_data_d  = mem.rdata;
            end
            OPC_POP: begin
              wb_write_d = 1'b1;
              wb_data_d  = mem.rdata;
              sp_write_d = 1'b1;
              sp_data_d  = sp_in_q;
            end
            OPC_PUSH: begin
              sp_write_d = 1'b1;
              sp_data_d  = sp_in_q;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
            state_d    = MS_IDLE;
            req_d      = 1'b0;
            wb_valid_d = 1'b1;
            bus_err_d  = 1'b1;
          end
        end
      end
      default: state_d = MS_IDLE;
    endcase

    stall_d = (state_d != MS_IDLE);
  end

  assign stall_o     = stall_q;
  assign mem.req     = req_q;
  assign mem.we      = cmd_q.we;
  assign mem.addr    = cmd_q.addr;
  assign mem.wdata   = cmd_q.wdata;
  assign wb_valid_o  = wb_valid_q;
  assign wb_write_o  = wb_write_q;
  assign wb_data_o   = wb_data_q;
  assign sp_write_o  = sp_write_q;
  assign sp_data_o   = sp_data_q;
  assign align_err_o = align_err_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected bus/writeback events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  alu_control;
  logic [15:0] alu_out, store_data, sp_in;
  logic        alu_write;
  logic        stall_o, wb_valid_o, wb_write_o, sp_write_o, align_err_o, bus_err_o;
  logic [15:0] wb_data_o, sp_data_o;

  int total = 0;
  int bad   = 0;

  mem_stage_if mem ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en_i(en), .alu_control_i(alu_control), .alu_out_i(alu_out),
    .store_data_i(store_data), .alu_write_i(alu_write), .sp_in_i(sp_in), .stall_o(stall_o),
    .mem(mem.master), .wb_valid_o(wb_valid_o), .wb_write_o(wb_write_o), .wb_data_o(wb_data_o),
    .sp_write_o(sp_write_o), .sp_data_o(sp_data_o), .align_err_o(align_err_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] data;
    logic        chk_data;
    logic        sp_write;
    logic [15:0] sp_data;
    logic        align;
    logic        berr;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          len;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic w, input logic [15:0] d, input logic cd, input logic spw,
                         input logic [15:0] spd, input logic al, input logic be);
    wb_exp_t e;
    e.write = w; e.data = d; e.chk_data = cd; e.sp_write = spw; e.sp_data = spd;
    e.align = al; e.berr = be;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [15:0] a, input logic [15:0] wd,
                          input int len);
    bus_exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.len = len;
    bus_q.push_back(e);
  endtask

  // Monitor: bus requests and writeback pulses against the scoreboard queues
  bus_exp_t cur_bus;
  bit       have_bus = 0;
  bit       in_req   = 0;
  int       req_len  = 0;

  always @(negedge clk) begin
    if (mem.req) begin
      if (!in_req) begin
        in_req  = 1;
        req_len = 0;
        if (bus_q.size() == 0) begin
          have_bus = 0;
          total++; bad++;
          $display("FAIL bus_unexpected: got mem_req=1 expected no request at %0t", $time);
        end else begin
          cur_bus  = bus_q.pop_front();
          have_bus = 1;
        end
      end
      req_len++;
      if (have_bus) begin
        chk("bus_we", 32'(mem.we), 32'(cur_bus.we));
        chk("bus_addr", 32'(mem.addr), 32'(cur_bus.addr));
        chk("bus_wdata", 32'(mem.wdata), 32'(cur_bus.wdata));
      end
    end else if (in_req) begin
      in_req = 0;
      if (have_bus) chk("bus_len", 32'(req_len), 32'(cur_bus.len));
    end

    if (wb_valid_o) begin
      if (wb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected: got wb_valid=1 expected no writeback at %0t", $time);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        chk("wb_write", 32'(wb_write_o), 32'(e.write));
        if (e.chk_data) chk("wb_data", 32'(wb_data_o), 32'(e.data));
        chk("sp_write", 32'(sp_write_o), 32'(e.sp_write));
        if (e.sp_write) chk("sp_data", 32'(sp_data_o), 32'(e.sp_data));
        chk("align_err", 32'(align_err_o), 32'(e.align));
        chk("bus_err", 32'(bus_err_o), 32'(e.berr));
      end
    end else if (align_err_o || bus_err_o) begin
      total++; bad++;
      $display("FAIL err_without_wb: got align=%b bus=%b expected wb_valid=1 at %0t",
               align_err_o, bus_err_o, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] opc, input logic [15:0] aout, input logic [15:0] sd,
                       input logic w, input logic [15:0] sp);
    en = 1'b1; alu_control = opc; alu_out = aout; store_data = sd; alu_write = w; sp_in = sp;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_req"}, 32'(mem.req), 32'd0);
    chk({tag, "_we"}, 32'(mem.we), 32'd0);
    chk({tag, "_addr"}, 32'(mem.addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem.wdata), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid_o), 32'd0);
    chk({tag, "_wbw"}, 32'(wb_write_o), 32'd0);
    chk({tag, "_wbd"}, 32'(wb_data_o), 32'd0);
    chk({tag, "_spw"}, 32'(sp_write_o), 32'd0);
    chk({tag, "_spd"}, 32'(sp_data_o), 32'd0);
    chk({tag, "_align"}, 32'(align_err_o), 32'd0);
    chk({tag, "_berr"}, 32'(bus_err_o), 32'd0);
  endtask

  // Accept a memory op, then act as the slave for n BUS cycles (ack in the last if requested)
  task automatic run_mem(input logic [7:0] opc, input logic [15:0] aout, input logic [15:0] sd,
                         input logic [15:0] sp, input int n, input bit ack_last,
                         input logic [15:0] rd);
    drive(opc, aout, sd, 1'b0, sp);
    step();
    en = 1'b0;
    for (int i = 1; i <= n; i++) begin
      chk("stall_bus", 32'(stall_o), 32'd1);
      if (i == n && ack_last) begin
        mem.ack = 1'b1;
        mem.rdata = rd;
      end
      step();
      mem.ack = 1'b0;
      mem.rdata = 16'h0000;
    end
    chk("stall_done", 32'(stall_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; alu_control = '0; alu_out = '0; store_data = '0;
    alu_write = 1'b0; sp_in = '0; mem.ack = 1'b0; mem.rdata = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Pass-through ADD
    push_wb(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(OPC_ADD, 16'h1234, 16'h0, 1'b1, 16'h0);
    step();
    en = 1'b0;
    chk("add_stall", 32'(stall_o), 32'd0);
    step();

    // Back-to-back pass-through ops
    push_wb(1'b0, 16'h0001, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    push_wb(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(OPC_ADD, 16'h0001, 16'h0, 1'b0, 16'h0);
    step();
    drive(OPC_XOR, 16'hFFFF, 16'h0, 1'b1, 16'h0);
    step();
    en = 1'b0;
    step();

    // LD, ack on the third BUS cycle
    push_bus(1'b0, 16'h0040, 16'h1111, 3);
    push_wb(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    run_mem(OPC_LD, 16'h0040, 16'h1111, 16'h0, 3, 1'b1, 16'hBEEF);

    // PUSH, POP, ST issued back to back after each completion
    push_bus(1'b1, 16'h7FFE, 16'hA5A5, 1);
    push_wb(1'b0, 16'h0, 1'b0, 1'b1, 16'h7FFE, 1'b0, 1'b0);
    run_mem(OPC_PUSH, 16'h7FFE, 16'hA5A5, 16'h7FFE, 1, 1'b1, 16'h0);
    push_bus(1'b0, 16'h7FFE, 16'h0000, 2);
    push_wb(1'b1, 16'h5A5A, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b0);
    run_mem(OPC_POP, 16'h7FFE, 16'h0000, 16'h8000, 2, 1'b1, 16'h5A5A);
    push_bus(1'b1, 16'h0100, 16'hCAFE, 1);
    push_wb(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    run_mem(OPC_ST, 16'h0100, 16'hCAFE, 16'h0, 1, 1'b1, 16'h0);
    step();

    // Misaligned ST and POP: error pulse, no bus cycle, no stall
    push_wb(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(OPC_ST, 16'h0041, 16'h3333, 1'b0, 16'h0);
    step();
    en = 1'b0;
    chk("align_st_stall", 32'(stall_o), 32'd0);
    step();
    chk("align_st_stall2", 32'(stall_o), 32'd0);
    push_wb(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(OPC_POP, 16'h0003, 16'h0, 1'b1, 16'h1234);
    step();
    en = 1'b0;
    chk("align_pop_stall", 32'(stall_o), 32'd0);
    step();

    // Timeout with no ack, then ack on the timeout edge
    push_bus(1'b0, 16'h0200, 16'h0000, 4);
    push_wb(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    run_mem(OPC_LD, 16'h0200, 16'h0000, 16'h0, 4, 1'b0, 16'h0);
    push_bus(1'b0, 16'h0202, 16'h0000, 4);
    push_wb(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    run_mem(OPC_LD, 16'h0202, 16'h0000, 16'h0, 4, 1'b1, 16'h7777);
    step();

    // ack while IDLE is ignored
    mem.ack = 1'b1;
    mem.rdata = 16'hDEAD;
    push_wb(1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(OPC_ADD, 16'h00AA, 16'h0, 1'b1, 16'h0);
    step();
    en = 1'b0;
    step();
    mem.ack = 1'b0;
    mem.rdata = 16'h0000;
    step();

    // Reset in the second BUS cycle discards the access
    push_bus(1'b0, 16'h0300, 16'h0000, 2);
    drive(OPC_LD, 16'h0300, 16'h0000, 1'b0, 16'h0);
    step();
    en = 1'b0;
    chk("rst_bus_stall", 32'(stall_o), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    step();
    push_wb(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(OPC_ADD, 16'h1234, 16'h0, 1'b1, 16'h0);
    step();
    en = 1'b0;
    chk("add2_stall", 32'(stall_o), 32'd0);

    repeat (4) step();
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
